// File: rtl/sspwm_sine_sched.sv
// Sine-PWM sample scheduler: carrier counter, shadowed config, phase accumulator,
// soft-start amplitude and a small ROM fetch FSM that produces the next-period duty word.
module sspwm_sine_sched #(
  parameter int PERIOD    = 2000,
  parameter int RAMP_STEP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_we,
  input  logic        cfg_en,
  input  logic [15:0] cfg_step,
  input  logic [7:0]  cfg_amp,
  output logic        rom_en,
  output logic [7:0]  rom_addr,
  input  logic [10:0] rom_data,
  output logic [10:0] duty,
  output logic        period_start,
  output logic        ramp_done,
  output logic        busy
);

  // state  | meaning
  // IDLE   | waiting for the next wrap edge
  // FETCH  | ROM read strobe out, address = phase[15:8]
  // WAIT   | ROM data valid, captured into sample
  // CALC   | scale, clamp, write duty_next
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_CALC  = 2'd3;

  localparam logic [10:0] PER  = 11'(PERIOD);
  localparam logic [10:0] HALF = 11'(PERIOD / 2);

  logic [10:0] cnt;
  logic        wrap;
  logic        pend_en;
  logic [15:0] pend_step;
  logic [7:0]  pend_amp;
  logic        en;
  logic [7:0]  amp_tgt;
  logic [7:0]  amp_cur;
  logic [15:0] phase;
  logic [1:0]  state;
  logic [10:0] sample;
  logic [10:0] duty_next;

  logic [8:0]         amp_sum;
  logic [7:0]         amp_ramp;
  logic signed [11:0] dev;
  logic signed [20:0] prod;
  logic signed [20:0] scaled;
  logic signed [21:0] v;
  logic [10:0]        duty_calc;

  assign wrap      = (cnt == PER);
  assign rom_en    = (state == S_FETCH);
  assign rom_addr  = phase[15:8];
  assign busy      = (state != S_IDLE);
  assign ramp_done = en && (amp_cur == amp_tgt);

  // Ramp up toward the incoming target, but drop straight to it when it is lower.
  assign amp_sum = {1'b0, amp_cur} + 9'(RAMP_STEP);
  always_comb begin
    amp_ramp = pend_amp;
    if ((pend_amp >= amp_cur) && (amp_sum < {1'b0, pend_amp}))
      amp_ramp = amp_sum[7:0];
  end

  assign dev    = $signed({1'b0, sample}) - 12'sd1024;
  assign prod   = $signed({{9{dev[11]}}, dev}) * $signed({13'd0, amp_cur});
  assign scaled = prod >>> 8;
  assign v      = $signed({scaled[20], scaled}) + $signed({11'd0, HALF});

  always_comb begin
    if (v[21])
      duty_calc = '0;
    else if (v > $signed({11'd0, PER}))
      duty_calc = PER;
    else
      duty_calc = v[10:0];
  end

  // At a wrap the pending values are the ones being loaded, so they drive the update directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      period_start <= 1'b0;
      pend_en      <= 1'b0;
      pend_step    <= '0;
      pend_amp     <= '0;
      en           <= 1'b0;
      amp_tgt      <= '0;
      amp_cur      <= '0;
      phase        <= '0;
      state        <= S_IDLE;
      sample       <= '0;
      duty_next    <= '0;
      duty         <= '0;
    end else begin
      period_start <= wrap;
      cnt          <= wrap ? 11'd0 : cnt + 11'd1;
      if (cfg_we) begin
        pend_en   <= cfg_en;
        pend_step <= cfg_step;
        pend_amp  <= cfg_amp;
      end
      if (wrap) begin
        en      <= pend_en;
        amp_tgt <= pend_amp;
        duty    <= duty_next;
        if (!pend_en) begin
          amp_cur   <= '0;
          phase     <= '0;
          duty_next <= '0;
          state     <= S_IDLE;
        end else begin
          phase   <= phase + pend_step;
          amp_cur <= amp_ramp;
          state   <= S_FETCH;
        end
      end else begin
        case (state)
          S_FETCH: state <= S_WAIT;
          S_WAIT: begin
            sample <= rom_data;
            state  <= S_CALC;
          end
          S_CALC: begin
            duty_next <= duty_calc;
            state     <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sspwm_sine_sched.sv
// Bench for sspwm_sine_sched: two instances (ramp step 1 and 255) sharing clock and reset,
// per-scenario tasks with queued expected values compared at each period start.
module tb_sspwm_sine_sched;
  localparam int PERIOD = 2000;

  logic        clk;
  logic        rst;
  logic        cfg_we_a, cfg_en_a, cfg_we_b, cfg_en_b;
  logic [15:0] cfg_step_a, cfg_step_b;
  logic [7:0]  cfg_amp_a, cfg_amp_b;
  logic        rom_en_a, rom_en_b;
  logic [7:0]  rom_addr_a, rom_addr_b;
  logic [10:0] rom_data_a, rom_data_b;
  logic [10:0] rom_val_a, rom_val_b;
  logic [10:0] duty_a, duty_b;
  logic        period_start_a, period_start_b;
  logic        ramp_done_a, ramp_done_b;
  logic        busy_a, busy_b;

  int n_tests = 0;
  int n_fail  = 0;
  int rom_cnt = 0;

  logic [10:0] duty_q[$];
  logic [7:0]  amp_q[$];
  logic        rd_q[$];
  logic [7:0]  addr_q[$];

  sspwm_sine_sched #(.PERIOD(PERIOD), .RAMP_STEP(1)) dut_a (
    .clk(clk), .rst(rst), .cfg_we(cfg_we_a), .cfg_en(cfg_en_a), .cfg_step(cfg_step_a),
    .cfg_amp(cfg_amp_a), .rom_en(rom_en_a), .rom_addr(rom_addr_a), .rom_data(rom_data_a),
    .duty(duty_a), .period_start(period_start_a), .ramp_done(ramp_done_a), .busy(busy_a));

  sspwm_sine_sched #(.PERIOD(PERIOD), .RAMP_STEP(255)) dut_b (
    .clk(clk), .rst(rst), .cfg_we(cfg_we_b), .cfg_en(cfg_en_b), .cfg_step(cfg_step_b),
    .cfg_amp(cfg_amp_b), .rom_en(rom_en_b), .rom_addr(rom_addr_b), .rom_data(rom_data_b),
    .duty(duty_b), .period_start(period_start_b), .ramp_done(ramp_done_b), .busy(busy_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle-latency ROM models returning a fixed sample
  always @(posedge clk) begin
    if (rst) begin
      rom_data_a <= '0;
      rom_data_b <= '0;
    end else begin
      if (rom_en_a) rom_data_a <= rom_val_a;
      if (rom_en_b) rom_data_b <= rom_val_b;
    end
  end

  always @(posedge clk) if (rom_en_a || rom_en_b) rom_cnt <= rom_cnt + 1;

  task automatic cfg_a(input logic en, input logic [15:0] step, input logic [7:0] amp);
    cfg_en_a = en; cfg_step_a = step; cfg_amp_a = amp; cfg_we_a = 1'b1;
    @(negedge clk);
    cfg_we_a = 1'b0;
  endtask

  task automatic cfg_b(input logic en, input logic [15:0] step, input logic [7:0] amp);
    cfg_en_b = en; cfg_step_b = step; cfg_amp_b = amp; cfg_we_b = 1'b1;
    @(negedge clk);
    cfg_we_b = 1'b0;
  endtask

  task automatic cycles_to_ps(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_start_a && n < 2100);
  endtask

  task automatic wait_ps();
    int n;
    cycles_to_ps(n);
    n_tests++;
    if (n >= 2100) begin
      n_fail++;
      $display("FAIL wait_period_start: no pulse within %0d cycles, required within 2001", n);
    end
  endtask

  task automatic test_reset();
    int n, r0;
    rst = 1'b1;
    cfg_we_a = 0; cfg_en_a = 0; cfg_step_a = '0; cfg_amp_a = '0;
    cfg_we_b = 0; cfg_en_b = 0; cfg_step_b = '0; cfg_amp_b = '0;
    rom_val_a = '0; rom_val_b = '0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({duty_a, period_start_a, rom_en_a, rom_addr_a, ramp_done_a, busy_a} !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_outputs_a: got duty=%0d ps=%b rom_en=%b addr=%0d rd=%b busy=%b, required all 0",
               duty_a, period_start_a, rom_en_a, rom_addr_a, ramp_done_a, busy_a);
    end
    n_tests++;
    if ({duty_b, period_start_b, busy_b} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_outputs_b: got duty=%0d ps=%b busy=%b, required all 0", duty_b, period_start_b, busy_b);
    end
    rst = 1'b0;
    r0 = rom_cnt;
    @(negedge clk);
    n_tests++;
    if (period_start_a !== 1'b0) begin
      n_fail++;
      $display("FAIL first_cycle_no_pulse: period_start=%b, required 0", period_start_a);
    end
    cycles_to_ps(n);
    n_tests++;
    if (n + 1 != 2001) begin
      n_fail++;
      $display("FAIL first_pulse_delay: %0d cycles after release, required 2001", n + 1);
    end
    for (int k = 0; k < 2; k++) begin
      cycles_to_ps(n);
      n_tests++;
      if (n != 2001) begin
        n_fail++;
        $display("FAIL pulse_spacing %0d: %0d cycles, required 2001", k, n);
      end
      n_tests++;
      if (duty_a !== 11'd0 || duty_b !== 11'd0) begin
        n_fail++;
        $display("FAIL idle_duty %0d: duty_a=%0d duty_b=%0d, required 0", k, duty_a, duty_b);
      end
    end
    n_tests++;
    if (rom_cnt != r0) begin
      n_fail++;
      $display("FAIL idle_rom_en: %0d rom_en cycles, required 0", rom_cnt - r0);
    end
  endtask

  task automatic test_clamp();
    logic [10:0] e;
    wait_ps();
    repeat (10) @(negedge clk);
    rom_val_b = 11'd2047;
    cfg_b(1'b1, 16'h0000, 8'd255);
    duty_q = {11'd0, 11'd2000, 11'd0, 11'd1256};
    for (int k = 1; k <= 4; k++) begin
      wait_ps();
      e = duty_q.pop_front();
      n_tests++;
      if (duty_b !== e) begin
        n_fail++;
        $display("FAIL clamp_duty wrap %0d: got %0d, required %0d", k, duty_b, e);
      end
      if (k == 1) begin
        repeat (10) @(negedge clk);
        rom_val_b = 11'd0;
      end else if (k == 2) begin
        repeat (10) @(negedge clk);
        rom_val_b = 11'd1536;
        cfg_b(1'b1, 16'h0000, 8'd128);
      end
    end
  endtask

  task automatic test_soft_start();
    logic [10:0] ed;
    logic [7:0]  ea;
    logic        er;
    wait_ps();
    repeat (10) @(negedge clk);
    rom_val_a = 11'd2047;
    cfg_a(1'b1, 16'h0000, 8'd4);
    duty_q = {11'd0, 11'd1003, 11'd1007, 11'd1011, 11'd1015, 11'd1015};
    amp_q  = {8'd1, 8'd2, 8'd3, 8'd4, 8'd4, 8'd4};
    rd_q   = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int k = 1; k <= 6; k++) begin
      wait_ps();
      ed = duty_q.pop_front(); ea = amp_q.pop_front(); er = rd_q.pop_front();
      n_tests++;
      if (duty_a !== ed) begin
        n_fail++;
        $display("FAIL soft_duty wrap %0d: got %0d, required %0d", k, duty_a, ed);
      end
      n_tests++;
      if (dut_a.amp_cur !== ea) begin
        n_fail++;
        $display("FAIL soft_amp wrap %0d: got %0d, required %0d", k, dut_a.amp_cur, ea);
      end
      n_tests++;
      if (ramp_done_a !== er) begin
        n_fail++;
        $display("FAIL soft_ramp_done wrap %0d: got %b, required %b", k, ramp_done_a, er);
      end
    end
  endtask

  task automatic test_phase_wrap();
    logic [7:0] e;
    int nb;
    wait_ps();
    repeat (10) @(negedge clk);
    cfg_a(1'b1, 16'h4000, 8'd4);
    addr_q = {8'h40, 8'h80, 8'hC0, 8'h00, 8'h40};
    for (int k = 1; k <= 5; k++) begin
      wait_ps();
      e = addr_q.pop_front();
      n_tests++;
      if (rom_en_a !== 1'b1 || rom_addr_a !== e) begin
        n_fail++;
        $display("FAIL phase_addr wrap %0d: rom_en=%b addr=%h, required rom_en=1 addr=%h", k, rom_en_a, rom_addr_a, e);
      end
      if (k == 1) begin
        nb = busy_a ? 1 : 0;
        repeat (PERIOD - 1) begin
          @(negedge clk);
          if (busy_a) nb++;
        end
        n_tests++;
        if (nb != 3) begin
          n_fail++;
          $display("FAIL busy_cycles: %0d cycles, required 3", nb);
        end
      end
    end
  endtask

  task automatic test_cfg_in_wrap();
    logic [7:0]  ex_addr, ex_amp;
    logic [10:0] ex_duty;
    wait_ps();
    repeat (PERIOD) @(negedge clk);
    cfg_a(1'b1, 16'h0100, 8'd2);
    addr_q = {8'hC0, 8'hC1, 8'hC2};
    amp_q  = {8'd4, 8'd2, 8'd2};
    duty_q = {11'd1015, 11'd1015, 11'd1007};
    for (int k = 0; k < 3; k++) begin
      if (k > 0) wait_ps();
      ex_addr = addr_q.pop_front(); ex_amp = amp_q.pop_front(); ex_duty = duty_q.pop_front();
      n_tests++;
      if (rom_addr_a !== ex_addr || dut_a.amp_cur !== ex_amp) begin
        n_fail++;
        $display("FAIL cfg_wrap wrap %0d: addr=%h amp=%0d, required addr=%h amp=%0d", k, rom_addr_a, dut_a.amp_cur, ex_addr, ex_amp);
      end
      n_tests++;
      if (duty_a !== ex_duty) begin
        n_fail++;
        $display("FAIL cfg_wrap_duty wrap %0d: got %0d, required %0d", k, duty_a, ex_duty);
      end
    end
  endtask

  task automatic test_disable();
    logic [10:0] ed;
    logic [7:0]  ea;
    repeat (10) @(negedge clk);
    cfg_a(1'b1, 16'h0100, 8'd20);
    duty_q = {11'd1007, 11'd1011, 11'd0};
    amp_q  = {8'd3, 8'd0, 8'd0};
    for (int k = 1; k <= 3; k++) begin
      wait_ps();
      ed = duty_q.pop_front(); ea = amp_q.pop_front();
      n_tests++;
      if (duty_a !== ed || dut_a.amp_cur !== ea) begin
        n_fail++;
        $display("FAIL disable wrap %0d: duty=%0d amp=%0d, required duty=%0d amp=%0d", k, duty_a, dut_a.amp_cur, ed, ea);
      end
      if (k >= 2) begin
        n_tests++;
        if (dut_a.phase !== 16'h0000 || rom_en_a !== 1'b0) begin
          n_fail++;
          $display("FAIL disable_phase wrap %0d: phase=%h rom_en=%b, required 0000 and 0", k, dut_a.phase, rom_en_a);
        end
      end
      if (k == 1) begin
        repeat (10) @(negedge clk);
        cfg_a(1'b0, 16'h0100, 8'd20);
      end
    end
  endtask

  task automatic test_mid_fetch_reset();
    int n, r0;
    repeat (10) @(negedge clk);
    cfg_a(1'b1, 16'h0000, 8'd4);
    wait_ps();
    @(negedge clk);
    n_tests++;
    if (busy_a !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_state_busy: got %b, required 1", busy_a);
    end
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (busy_a !== 1'b0 || rom_en_a !== 1'b0 || duty_a !== 11'd0 || dut_a.state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_abort: busy=%b rom_en=%b duty=%0d state=%0d, required 0 0 0 0", busy_a, rom_en_a, duty_a, dut_a.state);
    end
    rst = 1'b0;
    r0 = rom_cnt;
    cycles_to_ps(n);
    n_tests++;
    if (n != 2001) begin
      n_fail++;
      $display("FAIL post_reset_pulse: %0d cycles, required 2001", n);
    end
    wait_ps();
    n_tests++;
    if (rom_cnt != r0 || duty_a !== 11'd0 || duty_b !== 11'd0) begin
      n_fail++;
      $display("FAIL post_reset_disabled: rom_en cycles=%0d duty_a=%0d duty_b=%0d, required 0 0 0", rom_cnt - r0, duty_a, duty_b);
    end
  endtask

  initial begin
    test_reset();
    test_clamp();
    test_soft_start();
    test_phase_wrap();
    test_cfg_in_wrap();
    test_disable();
    test_mid_fetch_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
